// File: rtl/norm_result_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : norm_result_serializer_if
// Brief    : Wide-in / narrow-out AXIS bundle for the norm result serializer.
// Revision : 1.0 - initial release
// ============================================================================
interface norm_result_serializer_if #(
    parameter int LANES  = 8,
    parameter int LANE_W = 16
);
    logic [LANES*LANE_W-1:0] S_AXIS_TDATA;
    logic                    S_AXIS_TVALID;
    logic                    S_AXIS_TREADY;
    logic [LANE_W-1:0]       M_AXIS_TDATA;
    logic                    M_AXIS_TVALID;
    logic                    M_AXIS_TLAST;
    logic                    M_AXIS_TREADY;
    logic                    row_done;

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TVALID, M_AXIS_TREADY,
        output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, row_done
    );

    modport master (
        output S_AXIS_TDATA, S_AXIS_TVALID, M_AXIS_TREADY,
        input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, row_done
    );
endinterface
`default_nettype wire

// File: rtl/norm_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : norm_result_serializer
// Brief    : Splits packed bf16 beats into one element per handshake, lane 0
//            first, with TLAST on the last element of every row.
// Revision : 1.0 - initial release
// ============================================================================
module norm_result_serializer #(
    parameter int LANES   = 8,
    parameter int LANE_W  = 16,
    parameter int ROW_LEN = 64
) (
    input  wire logic               aclk,
    input  wire logic               arst,
    norm_result_serializer_if.slave bus
);
    localparam int c_BEAT_W = LANES * LANE_W;
    localparam int c_IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_CNT_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_LANE = c_IDX_W'(LANES - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_ELEM = c_CNT_W'(ROW_LEN - 1);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_ONE   = 2'd1;
    localparam logic [1:0] c_ST_TWO   = 2'd2;

    generate
        if ((ROW_LEN % LANES) != 0 || ROW_LEN < LANES) begin : g_row_len_check
            $error("ROW_LEN must be a non-zero multiple of LANES");
        end
    endgenerate

    logic [1:0]          r_state;
    logic [c_BEAT_W-1:0] r_cur;
    logic [c_BEAT_W-1:0] r_pend;
    logic [c_IDX_W-1:0]  r_lane_idx;
    logic [c_CNT_W-1:0]  r_elem_cnt;
    logic                r_row_done;

    logic w_m_valid;
    logic w_s_ready;
    logic w_in_hs;
    logic w_out_hs;
    logic w_last_lane;
    logic w_tlast;

    // The skid slot is occupied exactly in TWO, so readiness is a state decode.
    assign w_m_valid   = (r_state != c_ST_EMPTY);
    assign w_s_ready   = (r_state != c_ST_TWO) && !arst;
    assign w_in_hs     = bus.S_AXIS_TVALID && w_s_ready;
    assign w_out_hs    = w_m_valid && bus.M_AXIS_TREADY;
    assign w_last_lane = w_out_hs && (r_lane_idx == c_LAST_LANE);
    assign w_tlast     = w_m_valid && (r_elem_cnt == c_LAST_ELEM);

    assign bus.S_AXIS_TREADY = w_s_ready;
    assign bus.M_AXIS_TVALID = w_m_valid;
    assign bus.M_AXIS_TDATA  = r_cur[LANE_W-1:0];
    assign bus.M_AXIS_TLAST  = w_tlast;
    assign bus.row_done      = r_row_done;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_state    <= c_ST_EMPTY;
            r_cur      <= '0;
            r_pend     <= '0;
            r_lane_idx <= '0;
            r_elem_cnt <= '0;
            r_row_done <= 1'b0;
        end else begin
            r_row_done <= w_out_hs && w_tlast;

            if (w_out_hs) begin
                r_elem_cnt <= (r_elem_cnt == c_LAST_ELEM) ? '0 : r_elem_cnt + 1'b1;
            end

            case (r_state)
                c_ST_EMPTY: begin
                    if (w_in_hs) begin
                        r_cur      <= bus.S_AXIS_TDATA;
                        r_lane_idx <= '0;
                        r_state    <= c_ST_ONE;
                    end
                end
                c_ST_ONE: begin
                    if (w_last_lane) begin
                        // A beat arriving on the final lane reloads cur directly: no bubble.
                        r_lane_idx <= '0;
                        if (w_in_hs) begin
                            r_cur <= bus.S_AXIS_TDATA;
                        end else begin
                            r_state <= c_ST_EMPTY;
                        end
                    end else begin
                        if (w_out_hs) begin
                            r_cur      <= r_cur >> LANE_W;
                            r_lane_idx <= r_lane_idx + 1'b1;
                        end
                        if (w_in_hs) begin
                            r_pend  <= bus.S_AXIS_TDATA;
                            r_state <= c_ST_TWO;
                        end
                    end
                end
                c_ST_TWO: begin
                    if (w_last_lane) begin
                        r_cur      <= r_pend;
                        r_lane_idx <= '0;
                        r_state    <= c_ST_ONE;
                    end else if (w_out_hs) begin
                        r_cur      <= r_cur >> LANE_W;
                        r_lane_idx <= r_lane_idx + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_EMPTY;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_norm_result_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_norm_result_serializer
// Brief    : Directed bench for the serializer; ROW_LEN 64 and 8 instances share stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_norm_result_serializer;
    localparam int c_LANES  = 8;
    localparam int c_LANE_W = 16;

    logic         aclk = 1'b0;
    logic         arst = 1'b1;
    logic [127:0] s_tdata = '0;
    logic         s_valid = 1'b0;
    logic         m_ready = 1'b1;
    logic         rand_ready = 1'b0;

    int vectors = 0;
    int errors  = 0;

    norm_result_serializer_if #(.LANES(c_LANES), .LANE_W(c_LANE_W)) bus64 ();
    norm_result_serializer_if #(.LANES(c_LANES), .LANE_W(c_LANE_W)) bus8 ();

    assign bus64.S_AXIS_TDATA  = s_tdata;
    assign bus64.S_AXIS_TVALID = s_valid;
    assign bus64.M_AXIS_TREADY = m_ready;
    assign bus8.S_AXIS_TDATA   = s_tdata;
    assign bus8.S_AXIS_TVALID  = s_valid;
    assign bus8.M_AXIS_TREADY  = m_ready;

    norm_result_serializer #(.LANES(c_LANES), .LANE_W(c_LANE_W), .ROW_LEN(64)) u_dut64 (
        .aclk (aclk),
        .arst (arst),
        .bus  (bus64)
    );

    norm_result_serializer #(.LANES(c_LANES), .LANE_W(c_LANE_W), .ROW_LEN(8)) u_dut8 (
        .aclk (aclk),
        .arst (arst),
        .bus  (bus8)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] mk_beat(input int b);
        logic [127:0] d;
        d = '0;
        for (int l = 0; l < 8; l++) d[16*l +: 16] = {8'(b), 8'(l)};
        return d;
    endfunction

    // Model: a FIFO of outstanding elements plus per-instance row position.
    logic [15:0] exp_q[$];
    int  n;
    int  cnt64 = 0, cnt8 = 0;
    bit  rd64_exp = 0, rd8_exp = 0;
    bit  out_hs, in_hs;
    int  n_tl64 = 0, n_tl8 = 0, n_rd64 = 0, n_rd8 = 0;

    always @(negedge aclk) begin
        if (arst) begin
            chk("rst_m_valid64", bus64.M_AXIS_TVALID, 0);
            chk("rst_m_valid8", bus8.M_AXIS_TVALID, 0);
            chk("rst_s_ready64", bus64.S_AXIS_TREADY, 0);
            chk("rst_tlast64", bus64.M_AXIS_TLAST, 0);
            chk("rst_row_done64", bus64.row_done, 0);
            chk("rst_row_done8", bus8.row_done, 0);
            exp_q.delete();
            cnt64 = 0; cnt8 = 0; rd64_exp = 0; rd8_exp = 0;
        end else begin
            n = exp_q.size();
            chk("s_ready64", bus64.S_AXIS_TREADY, 32'(n <= c_LANES));
            chk("s_ready8", bus8.S_AXIS_TREADY, 32'(n <= c_LANES));
            chk("m_valid64", bus64.M_AXIS_TVALID, 32'(n > 0));
            chk("m_valid8", bus8.M_AXIS_TVALID, 32'(n > 0));
            if (n > 0) begin
                chk("tdata64", bus64.M_AXIS_TDATA, exp_q[0]);
                chk("tdata8", bus8.M_AXIS_TDATA, exp_q[0]);
                chk("tlast64", bus64.M_AXIS_TLAST, 32'(cnt64 == 63));
                chk("tlast8", bus8.M_AXIS_TLAST, 32'(cnt8 == 7));
            end
            chk("row_done64", bus64.row_done, rd64_exp);
            chk("row_done8", bus8.row_done, rd8_exp);
            if (bus64.row_done) n_rd64++;
            if (bus8.row_done) n_rd8++;
            if (bus64.M_AXIS_TVALID && m_ready && bus64.M_AXIS_TLAST) n_tl64++;
            if (bus8.M_AXIS_TVALID && m_ready && bus8.M_AXIS_TLAST) n_tl8++;
            out_hs   = (n > 0) && m_ready;
            in_hs    = s_valid && (n <= c_LANES);
            rd64_exp = out_hs && (cnt64 == 63);
            rd8_exp  = out_hs && (cnt8 == 7);
            if (out_hs) begin
                void'(exp_q.pop_front());
                cnt64 = (cnt64 + 1) % 64;
                cnt8  = (cnt8 + 1) % 8;
            end
            if (in_hs) begin
                for (int l = 0; l < c_LANES; l++) exp_q.push_back(s_tdata[16*l +: 16]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [127:0] d);
        int g;
        g = 0;
        s_tdata = d;
        s_valid = 1'b1;
        @(negedge aclk);
        while (!bus64.S_AXIS_TREADY && g < 2000) begin
            @(negedge aclk);
            g++;
        end
        if (g >= 2000) begin
            vectors++; errors++;
            $display("FAIL send_timeout: got stalled expected accept");
        end
        @(posedge aclk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge aclk);
        while (bus64.M_AXIS_TVALID && g < 5000) begin
            @(negedge aclk);
            g++;
        end
        if (g >= 5000) begin
            vectors++; errors++;
            $display("FAIL drain_timeout: got m_valid stuck expected idle");
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        arst = 1'b1;
        @(posedge aclk);
        #1;
        arst = 1'b0;
    endtask

    int          tl0, rd0, tl8_0, rd8_0, g;
    logic [15:0] e;

    initial begin
        repeat (2) @(posedge aclk);
        #1;
        arst = 1'b0;
        @(negedge aclk);
        chk("post_rst_s_ready", bus64.S_AXIS_TREADY, 1);
        chk("post_rst_m_valid", bus64.M_AXIS_TVALID, 0);
        @(posedge aclk);
        #1;

        // Single beat, one element per cycle starting the cycle after accept.
        send(128'h0008_0007_0006_0005_0004_0003_0002_0001);
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            e = 16'(k + 1);
            chk("single_tdata", bus64.M_AXIS_TDATA, e);
            chk("single_tlast", bus64.M_AXIS_TLAST, 0);
        end
        @(negedge aclk);
        chk("single_empty", bus64.M_AXIS_TVALID, 0);
        @(posedge aclk);
        #1;

        // Eight beats back to back: 64 contiguous elements, one TLAST, one row_done.
        do_reset();
        send(mk_beat(1));
        fork
            begin
                for (int b = 2; b <= 8; b++) send(mk_beat(b));
            end
        join_none
        for (int k = 0; k < 64; k++) begin
            @(negedge aclk);
            e = {8'(k / 8 + 1), 8'(k % 8)};
            chk("row_valid", bus64.M_AXIS_TVALID, 1);
            chk("row_tdata", bus64.M_AXIS_TDATA, e);
            chk("row_tlast", bus64.M_AXIS_TLAST, 32'(k == 63));
        end
        @(negedge aclk);
        chk("row_done_pulse", bus64.row_done, 1);
        chk("row_end_empty", bus64.M_AXIS_TVALID, 0);
        @(posedge aclk);
        #1;

        // Two beats on consecutive cycles: skid fills, ready returns after lane 7.
        do_reset();
        send(mk_beat(1));
        send(mk_beat(2));
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            chk("skid_s_ready", bus64.S_AXIS_TREADY, 32'(i == 7));
        end
        chk("skid_next_lane0", bus64.M_AXIS_TDATA, 16'h0200);
        @(posedge aclk);
        #1;
        wait_idle();

        // Random backpressure over 16 beats: two rows for 64, sixteen for 8.
        do_reset();
        tl0 = n_tl64; rd0 = n_rd64; tl8_0 = n_tl8; rd8_0 = n_rd8;
        rand_ready = 1'b1;
        for (int b = 1; b <= 16; b++) send(mk_beat(b));
        wait_idle();
        rand_ready = 1'b0;
        m_ready = 1'b1;
        chk("rand_tlast64", n_tl64 - tl0, 2);
        chk("rand_row_done64", n_rd64 - rd0, 2);
        chk("rand_tlast8", n_tl8 - tl8_0, 16);
        chk("rand_row_done8", n_rd8 - rd8_0, 16);

        // Reset while lane 3 of beat 5 is presented and the skid slot is full.
        do_reset();
        fork
            begin
                for (int b = 1; b <= 6; b++) send(mk_beat(b));
            end
        join_none
        g = 0;
        @(negedge aclk);
        while (!(bus64.M_AXIS_TVALID && bus64.M_AXIS_TDATA == 16'h0503) && g < 500) begin
            @(negedge aclk);
            g++;
        end
        chk("midrow_found", 32'(g < 500), 1);
        chk("midrow_pend_full", bus64.S_AXIS_TREADY, 0);
        #1;
        arst = 1'b1;
        #1;
        chk("midrow_async_valid", bus64.M_AXIS_TVALID, 0);
        @(negedge aclk);
        @(posedge aclk);
        #1;
        arst = 1'b0;
        @(negedge aclk);
        chk("midrow_release_ready", bus64.S_AXIS_TREADY, 1);
        @(posedge aclk);
        #1;
        tl0 = n_tl64; rd0 = n_rd64;
        for (int b = 1; b <= 8; b++) send(mk_beat(b + 16));
        wait_idle();
        chk("midrow_new_row_tlast", n_tl64 - tl0, 1);
        chk("midrow_new_row_done", n_rd64 - rd0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
